// File: rtl/forwarding_pkg.sv
// Shared types for the forwarding/hazard unit: in-flight tags and long-op scoreboard slots.
// Fields are sized for the widest supported config (REGW <= 8, LATW <= 8); narrower configs zero-extend.
// No logic here, so no latency or backpressure of its own.
package forwarding_pkg;

    localparam int DEST_MAXW   = 8;
    localparam int CNT_MAXW    = 8;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                 valid;
        logic                 wen;
        logic [DEST_MAXW-1:0] dest;
        logic                 is_load;
    } fwd_tag_t;

    typedef struct packed {
        logic                 busy;
        logic [DEST_MAXW-1:0] dest;
        logic [CNT_MAXW-1:0]  count;
    } long_slot_t;

endpackage

// File: rtl/long_op_slot.sv
// One long-latency scoreboard entry: holds the destination and counts down to free.
// Busy from the cycle after load for max(lat,1) cycles; hit outputs are combinational.
// No backpressure: the parent only loads a slot that is currently free.
module long_op_slot
    import forwarding_pkg::*;
#(
    parameter int REGW = 5,
    parameter int LATW = 4,
    parameter int NSRC = 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 load_i,
    input  logic [REGW-1:0]      dest_i,
    input  logic [LATW-1:0]      lat_i,
    input  logic [NSRC*REGW-1:0] src_i,
    input  logic [REGW-1:0]      wdest_i,
    output logic                 busy_o,
    output logic [NSRC-1:0]      src_hit_o,
    output logic                 wdest_hit_o
);

    long_slot_t slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (load_i) begin
            slot_d.busy  = 1'b1;
            slot_d.dest  = DEST_MAXW'(dest_i);
            slot_d.count = (lat_i == '0) ? CNT_MAXW'(1) : CNT_MAXW'(lat_i);
        end else if (slot_q.busy) begin
            // The edge that sees count==1 is the last busy cycle's edge.
            if (slot_q.count == CNT_MAXW'(1)) begin
                slot_d.busy  = 1'b0;
                slot_d.count = '0;
            end else begin
                slot_d.count = slot_q.count - CNT_MAXW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) slot_q <= '0;
        else       slot_q <= slot_d;
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_hit
        assign src_hit_o[i] = slot_q.busy && (src_i[i*REGW +: REGW] != '0) &&
                              (slot_q.dest == DEST_MAXW'(src_i[i*REGW +: REGW]));
    end

    assign wdest_hit_o = slot_q.busy && (slot_q.dest == DEST_MAXW'(wdest_i));
    assign busy_o      = slot_q.busy;

endmodule

// File: rtl/forwarding_scoreboard.sv
// Bypass-select and hazard unit beside decode: tag pipeline of in-flight writers plus long-op scoreboard.
// fwd_sel/stall are same-cycle combinational; tags and slots update on the rising edge.
// Raises stall on load-use, long-op RAW/WAW or a full scoreboard; flush and idle decode mask it.
module forwarding_scoreboard
    import forwarding_pkg::*;
#(
    parameter  int NSRC    = 2,
    parameter  int NSTAGES = 3,
    parameter  int REGW    = 5,
    parameter  int NLONG   = 2,
    parameter  int LATW    = 4,
    localparam int SELW    = $clog2(NSTAGES + 1)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 advance,
    input  logic                 flush,
    input  logic                 issue_valid,
    input  logic                 issue_wen,
    input  logic [REGW-1:0]      issue_dest,
    input  logic                 issue_is_load,
    input  logic                 issue_is_long,
    input  logic [LATW-1:0]      issue_lat,
    input  logic [NSRC*REGW-1:0] src_reg,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall,
    output logic [NLONG-1:0]     long_busy
);

    fwd_tag_t                     tag_q [NSTAGES];
    fwd_tag_t                     tag_d [NSTAGES];
    fwd_tag_t                     issued;
    logic [NSRC-1:0]              ld_hit;
    logic [NLONG-1:0]             busy;
    logic [NLONG-1:0][NSRC-1:0]   src_hit;
    logic [NLONG-1:0]             wdest_hit;
    logic [NLONG-1:0]             alloc_oh;
    logic                         accept;
    logic                         alloc_go;

    // Youngest producer wins: scan oldest to youngest so the last hit is stage 0.
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [REGW-1:0] src;
        logic [SELW-1:0] sel;

        assign src = src_reg[i*REGW +: REGW];

        always_comb begin
            sel = SELW'(FWD_REGFILE);
            for (int s = NSTAGES - 1; s >= 0; s--) begin
                if (src != '0 && tag_q[s].valid && tag_q[s].wen &&
                    tag_q[s].dest == DEST_MAXW'(src))
                    sel = SELW'(s + 1);
            end
        end

        assign fwd_sel[i*SELW +: SELW] = sel;
        assign ld_hit[i] = (sel == SELW'(1)) && tag_q[0].is_load;
    end

    assign stall = issue_valid && !flush &&
                   ((|ld_hit) || (|src_hit) || (issue_wen && (|wdest_hit)) ||
                    (issue_is_long && (&busy)));

    assign accept   = issue_valid && !flush && !stall;
    assign alloc_go = accept && issue_is_long && issue_wen && advance;
    // Lowest clear bit of busy: only slots free at the start of the cycle are eligible.
    assign alloc_oh = ~busy & (busy + NLONG'(1));

    always_comb begin
        issued.valid   = 1'b1;
        issued.wen     = issue_wen;
        issued.dest    = DEST_MAXW'(issue_dest);
        issued.is_load = issue_is_load;
        for (int s = 0; s < NSTAGES; s++) tag_d[s] = tag_q[s];
        if (advance) begin
            for (int s = 1; s < NSTAGES; s++) tag_d[s] = tag_q[s-1];
            tag_d[0] = (accept && !issue_is_long) ? issued : '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int s = 0; s < NSTAGES; s++) tag_q[s] <= '0;
        end else begin
            for (int s = 0; s < NSTAGES; s++) tag_q[s] <= tag_d[s];
        end
    end

    for (genvar k = 0; k < NLONG; k++) begin : g_slot
        long_op_slot #(
            .REGW (REGW),
            .LATW (LATW),
            .NSRC (NSRC)
        ) u_slot (
            .CLK         (CLK),
            .nRST        (nRST),
            .load_i      (alloc_go && alloc_oh[k]),
            .dest_i      (issue_dest),
            .lat_i       (issue_lat),
            .src_i       (src_reg),
            .wdest_i     (issue_dest),
            .busy_o      (busy[k]),
            .src_hit_o   (src_hit[k]),
            .wdest_hit_o (wdest_hit[k])
        );
    end

    assign long_busy = busy;

endmodule
